ram_access_master: RTL and testbench

//  Initiator for the single-port RAM en/wr_rd/addr/din/valid -> dout/ready/error interface.

---
 rtl/ram_if_pkg.sv | 19 +
 rtl/ram_watchdog.sv | 29 ++
 rtl/ram_access_master.sv | 152 +++++++++++++++
 tb/tb_ram_access_master.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_if_pkg.sv
// Shared types and default sizing for the single-port RAM initiator.
// Command direction encoding matches the RAM wr_rd pin.
package ram_if_pkg;

    localparam int          DEF_ADDR_WIDTH = 5;
    localparam int          DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_MEM_DEPTH  = 32;
    localparam int          DEF_TIMEOUT    = 16;

    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/ram_watchdog.sv
// Wait-cycle counter for an outstanding RAM access.
// o_tc flags the final allowed cycle (count == TIMEOUT-1).
module ram_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ram_access_master.sv
// Single-transaction initiator: command port -> single-port RAM -> response port.
// Illegal addresses are answered with an error without touching the RAM.
module ram_access_master
    import ram_if_pkg::*;
#(
    parameter int          ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int          DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int          TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr_rd,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_wr_rd,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_timeout,
    output logic                  en,
    output logic                  valid,
    output logic                  wr_rd,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] din,
    input  logic [DATA_WIDTH-1:0] dout,
    input  logic                  ready,
    input  logic                  error,
    output logic                  busy,
    output logic [15:0]           txn_count
);

    state_t                r_state;
    logic                  r_cmd_ready;
    logic                  r_rsp_valid;
    logic                  r_rsp_wr_rd;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_error;
    logic                  r_rsp_timeout;
    logic                  r_en;
    logic                  r_wr_rd;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;
    logic                  r_busy;
    logic [15:0]           r_txn_count;

    logic w_accept;
    logic w_legal;
    logic w_tc;

    assign w_accept = cmd_valid && r_cmd_ready;
    assign w_legal  = (32'(cmd_addr) < MEM_DEPTH);

    ram_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk      (clk),
        .rstn     (rstn),
        .i_clear  (r_state != ACCESS),
        .i_enable (r_state == ACCESS),
        .o_tc     (w_tc)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= IDLE;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_wr_rd   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_error   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_en          <= 1'b0;
            r_wr_rd       <= 1'b0;
            r_addr        <= '0;
            r_din         <= '0;
            r_busy        <= 1'b0;
            r_txn_count   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_rsp_wr_rd <= cmd_wr_rd;
                        if (w_legal) begin
                            r_en    <= 1'b1;
                            r_wr_rd <= cmd_wr_rd;
                            r_addr  <= cmd_addr;
                            r_din   <= (cmd_wr_rd == WR) ? cmd_wdata : '0;
                            r_state <= ACCESS;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_error <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= RESP;
                        end
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                ACCESS: begin
                    // ready has priority over the watchdog on the same edge
                    if (ready || w_tc) begin
                        r_en          <= 1'b0;
                        r_wr_rd       <= 1'b0;
                        r_addr        <= '0;
                        r_din         <= '0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_error   <= ready ? error : 1'b1;
                        r_rsp_timeout <= !ready;
                        r_rsp_rdata   <= (ready && !error && r_wr_rd == RD)
                                         ? dout : '0;
                        r_state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid   <= 1'b0;
                        r_rsp_wr_rd   <= 1'b0;
                        r_rsp_rdata   <= '0;
                        r_rsp_error   <= 1'b0;
                        r_rsp_timeout <= 1'b0;
                        r_txn_count   <= r_txn_count + 16'd1;
                        r_cmd_ready   <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_wr_rd   = r_rsp_wr_rd;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_error   = r_rsp_error;
    assign rsp_timeout = r_rsp_timeout;
    assign en          = r_en;
    assign valid       = r_en;
    assign wr_rd       = r_wr_rd;
    assign addr        = r_addr;
    assign din         = r_din;
    assign busy        = r_busy;
    assign txn_count   = r_txn_count;

endmodule

// File: tb/tb_ram_access_master.sv
// Directed bench for ram_access_master with a behavioural single-port RAM.
// RAM latency, error and hang are set per vector.
module tb_ram_access_master;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_wr_rd = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_wr_rd;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic          rsp_timeout;
    logic          en;
    logic          valid;
    logic          wr_rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout = '0;
    logic          ready = 1'b0;
    logic          error = 1'b0;
    logic          busy;
    logic [15:0]   txn_count;

    ram_access_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (32),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_wr_rd   (cmd_wr_rd),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_wr_rd   (rsp_wr_rd),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .rsp_timeout (rsp_timeout),
        .en          (en),
        .valid       (valid),
        .wr_rd       (wr_rd),
        .addr        (addr),
        .din         (din),
        .dout        (dout),
        .ready       (ready),
        .error       (error),
        .busy        (busy),
        .txn_count   (txn_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int exp_count = 0;
    int zero_viol = 0;

    // RAM model: ready after ram_lat wait cycles of a held request
    logic [DW-1:0] mem [64] = '{default: '0};
    int ram_lat = 0;
    bit ram_err = 1'b0;
    bit ram_hang = 1'b0;
    int wcnt = 0;

    always @(negedge clk) begin
        if (en && valid && !ram_hang) begin
            if (wcnt == ram_lat) begin
                ready = 1'b1;
                error = ram_err;
                dout  = wr_rd ? 32'hFFFF_FFFF : mem[addr];
                if (wr_rd && !ram_err) mem[addr] = din;
                wcnt = 0;
            end else begin
                ready = 1'b0;
                error = 1'b0;
                dout  = 32'h0BAD_0BAD;
                wcnt++;
            end
        end else begin
            ready = 1'b0;
            error = 1'b0;
            dout  = 32'h0BAD_0BAD;
            wcnt  = 0;
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (!en && (wr_rd !== 1'b0 || addr !== '0 || din !== '0))
                zero_viol++;
            if (valid !== en) zero_viol++;
        end
    end

    typedef struct {
        bit          wr;
        logic [5:0]  a;
        logic [31:0] wdata;
        int          lat;
        bit          err;
        bit          hang;
        logic [31:0] e_rdata;
        bit          e_error;
        bit          e_to;
        int          e_en;
    } vec_t;

    vec_t v [12];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic issue(input bit wr, input logic [5:0] a,
                         input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_wr_rd = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_wdata = '0;
    endtask

    task automatic wait_rsp(output int en_cyc);
        int n;
        n = 0;
        en_cyc = 0;
        @(negedge clk);
        while (!rsp_valid && n < 100) begin
            if (en) en_cyc++;
            @(negedge clk);
            n++;
        end
        check("rsp_wait", 32'(rsp_valid), 32'd1);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_count++;
        check("txn_count", 32'(txn_count), 32'(exp_count));
        check("rsp_drop", {30'd0, rsp_valid, cmd_ready}, 32'd1);
    endtask

    initial begin
        int ec;
        v[0]  = '{1, 6'h05, 32'hDEADBEEF, 1,  0, 0, 32'h0,        0, 0, 2};
        v[1]  = '{0, 6'h05, 32'h0,        1,  0, 0, 32'hDEADBEEF, 0, 0, 2};
        v[2]  = '{1, 6'h1F, 32'hA5A5A5A5, 0,  0, 0, 32'h0,        0, 0, 1};
        v[3]  = '{0, 6'h1F, 32'h0,        2,  0, 0, 32'hA5A5A5A5, 0, 0, 3};
        v[4]  = '{1, 6'h20, 32'h12345678, 0,  0, 0, 32'h0,        1, 0, 0};
        v[5]  = '{0, 6'h20, 32'h0,        0,  0, 0, 32'h0,        1, 0, 0};
        v[6]  = '{0, 6'h05, 32'h0,        0,  0, 1, 32'h0,        1, 1, 16};
        v[7]  = '{0, 6'h05, 32'h0,        0,  1, 0, 32'h0,        1, 0, 1};
        v[8]  = '{0, 6'h05, 32'h0,        15, 0, 0, 32'hDEADBEEF, 0, 0, 16};
        v[9]  = '{0, 6'h05, 32'h0,        16, 0, 0, 32'h0,        1, 1, 16};
        v[10] = '{1, 6'h00, 32'h12345678, 0,  0, 0, 32'h0,        0, 0, 1};
        v[11] = '{0, 6'h00, 32'h0,        0,  0, 0, 32'h12345678, 0, 0, 1};

        #1;
        check("rst_outs", {26'd0, cmd_ready, rsp_valid, en, valid, busy,
                           rsp_error}, 32'd0);
        check("rst_cnt", 32'(txn_count), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            ram_lat  = v[i].lat;
            ram_err  = v[i].err;
            ram_hang = v[i].hang;
            issue(v[i].wr, v[i].a, v[i].wdata);
            wait_rsp(ec);
            check($sformatf("v%0d_error", i), 32'(rsp_error),
                  32'(v[i].e_error));
            check($sformatf("v%0d_timeout", i), 32'(rsp_timeout),
                  32'(v[i].e_to));
            check($sformatf("v%0d_rdata", i), rsp_rdata, v[i].e_rdata);
            check($sformatf("v%0d_wr_rd", i), 32'(rsp_wr_rd), 32'(v[i].wr));
            check($sformatf("v%0d_en_cycles", i), ec, v[i].e_en);
            check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
            consume();
            ram_hang = 1'b0;
            ram_err  = 1'b0;
        end
        check("ram_hole_untouched", mem[32], 32'h0);

        // Response back-pressure, then back-to-back command
        ram_lat = 0;
        issue(1'b0, 6'h1F, 32'h0);
        wait_rsp(ec);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, 32'hA5A5A5A5);
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_wr_rd = 1'b0;
        cmd_addr  = 6'h05;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_count++;
        check("bp_ready_after", {29'd0, cmd_ready, rsp_valid, en}, 32'd4);
        check("bp_count", 32'(txn_count), 32'(exp_count));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("bp_accept_en", 32'(en), 32'd1);
        wait_rsp(ec);
        check("bp_rdata", rsp_rdata, 32'hDEADBEEF);
        consume();

        // Reset in the middle of an access
        ram_hang = 1'b1;
        issue(1'b0, 6'h05, 32'h0);
        repeat (3) @(negedge clk);
        check("mid_en", 32'(en), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_outs", {27'd0, en, valid, rsp_valid, busy, cmd_ready},
              32'd0);
        check("arst_cnt", 32'(txn_count), 32'd0);
        exp_count = 0;
        ram_hang = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_stale", {30'd0, rsp_valid, en}, 32'd0);
        end
        ram_lat = 1;
        issue(1'b0, 6'h05, 32'h0);
        wait_rsp(ec);
        check("post_rst_rdata", rsp_rdata, 32'hDEADBEEF);
        check("post_rst_err", {30'd0, rsp_error, rsp_timeout}, 32'd0);
        check("post_rst_en", ec, 2);
        consume();

        check("en0_quiet", zero_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
